// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - time-counter display stage: binary-to-BCD conversion and 6-digit seven-segment scan
module clock_display_scan #(
  parameter int SCAN_DIV    = 1000,
  parameter bit BLANK_HTENS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       load,
  output logic       busy,
  output logic       range_err,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_cnt;
  logic [5:0]    r_bin_s;
  logic [5:0]    r_bin_m;
  logic [5:0]    r_bin_h;
  logic [7:0]    r_bcd_s;
  logic [7:0]    r_bcd_m;
  logic [7:0]    r_bcd_h;
  logic          r_err_pend;
  logic [23:0]   r_disp;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_digit;
  logic [7:0]    w_bcd_s_next;
  logic [7:0]    w_bcd_m_next;
  logic [7:0]    w_bcd_h_next;
  logic [3:0]    w_nib;

  // One double-dabble step on a two-digit BCD accumulator: add-3 correction, then shift in s.
  function automatic logic [7:0] dabble(input logic [7:0] b, input logic s);
    logic [7:0] a;
    a = b;
    if (a[3:0] >= 4'd5) a[3:0] = a[3:0] + 4'd3;
    if (a[7:4] >= 4'd5) a[7:4] = a[7:4] + 4'd3;
    return (a << 1) | {7'b0, s};
  endfunction

  assign w_bcd_s_next = dabble(r_bcd_s, r_bin_s[5]);
  assign w_bcd_m_next = dabble(r_bcd_m, r_bin_m[5]);
  assign w_bcd_h_next = dabble(r_bcd_h, r_bin_h[5]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (load) w_state_next = S_SHIFT;
      S_SHIFT:  if (r_cnt == 3'd5) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 3'd0;
      r_bin_s    <= 6'd0;
      r_bin_m    <= 6'd0;
      r_bin_h    <= 6'd0;
      r_bcd_s    <= 8'd0;
      r_bcd_m    <= 8'd0;
      r_bcd_h    <= 8'd0;
      r_err_pend <= 1'b0;
      r_disp     <= 24'd0;
      range_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin_s    <= sec;
            r_bin_m    <= min;
            r_bin_h    <= {1'b0, hour};
            r_bcd_s    <= 8'd0;
            r_bcd_m    <= 8'd0;
            r_bcd_h    <= 8'd0;
            r_cnt      <= 3'd0;
            r_err_pend <= (sec > 6'd59) || (min > 6'd59) || (hour > 5'd23);
          end
        end
        S_SHIFT: begin
          r_bcd_s <= w_bcd_s_next;
          r_bcd_m <= w_bcd_m_next;
          r_bcd_h <= w_bcd_h_next;
          r_bin_s <= {r_bin_s[4:0], 1'b0};
          r_bin_m <= {r_bin_m[4:0], 1'b0};
          r_bin_h <= {r_bin_h[4:0], 1'b0};
          r_cnt   <= r_cnt + 3'd1;
        end
        S_COMMIT: begin
          r_disp    <= {r_bcd_h, r_bcd_m, r_bcd_s};
          range_err <= r_err_pend;
        end
        default: ;
      endcase
    end
  end

  // Digit scan free-runs regardless of conversion activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_digit <= 3'd0;
    end else if (r_presc == PW'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_digit <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_nib = 4'h0;
    case (r_digit)
      3'd0:    w_nib = r_disp[3:0];
      3'd1:    w_nib = r_disp[7:4];
      3'd2:    w_nib = r_disp[11:8];
      3'd3:    w_nib = r_disp[15:12];
      3'd4:    w_nib = r_disp[19:16];
      3'd5:    w_nib = r_disp[23:20];
      default: w_nib = 4'h0;
    endcase
  end

  always_comb begin
    an = ~(6'b000001 << r_digit);
    dp = !((r_digit == 3'd2) || (r_digit == 3'd4));
    case (w_nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    if (BLANK_HTENS && (r_digit == 3'd5) && (w_nib == 4'h0)) seg = 7'h7F;
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - scoreboard bench for clock_display_scan
module tb_clock_display_scan;
  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [5:0] sec = 6'd0;
  logic [5:0] min = 6'd0;
  logic [4:0] hour = 5'd0;
  logic       busy, range_err, dp;
  logic [6:0] seg;
  logic [5:0] an;

  typedef struct packed {
    logic [23:0] nibs;
    logic        rerr;
    logic        phased;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_active = 1'b0;

  always #5 clk = ~clk;

  clock_display_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_HTENS(1'b0)) dut (
    .clk(clk), .rst(rst), .sec(sec), .min(min), .hour(hour), .load(load),
    .busy(busy), .range_err(range_err), .seg(seg), .dp(dp), .an(an)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int an_index(input logic [5:0] a);
    for (int i = 0; i < 6; i++)
      if (a === ~(6'b000001 << i)) return i;
    return -1;
  endfunction

  task automatic scan_check(input exp_t e, input bit phased);
    int idx;
    logic [3:0] nib;
    for (int k = 0; k < (phased ? 25 : 24); k++) begin
      if (k > 0) @(negedge clk);
      if (phased) chk("scan_order_an", {26'd0, an}, {26'd0, ~(6'b000001 << ((k / 4) % 6))});
      idx = an_index(an);
      if (idx < 0) begin
        chk("an_onehot", {26'd0, an}, 32'h3F);
      end else begin
        nib = e.nibs[idx*4 +: 4];
        chk($sformatf("seg_digit%0d", idx), {25'd0, seg}, {25'd0, seg_of(nib)});
        chk($sformatf("dp_digit%0d", idx), {31'd0, dp}, {31'd0, !(idx == 2 || idx == 4)});
        chk("range_err", {31'd0, range_err}, {31'd0, e.rerr});
        chk("busy_idle", {31'd0, busy}, 32'd0);
      end
    end
  endtask

  // Monitor: a busy falling edge marks a commit; a reset release marks a known display state.
  initial begin
    bit   prev_rst  = 1'b1;
    bit   prev_busy = 1'b0;
    int   bcnt      = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rst = 1'b1; prev_busy = 1'b0; bcnt = 0;
      end else if (prev_rst || (prev_busy && !busy)) begin
        mon_active = 1'b1;
        if (!prev_rst) chk("busy_cycles", bcnt, 32'd7);
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
          e = '0;
        end else begin
          e = q.pop_front();
        end
        chk("trigger_kind", {31'd0, prev_rst}, {31'd0, e.phased});
        scan_check(e, prev_rst);
        prev_rst = 1'b0; prev_busy = 1'b0; bcnt = 0;
        mon_active = 1'b0;
      end else begin
        if (busy) bcnt++;
        prev_busy = busy;
      end
    end
  end

  task automatic pulse(input int h, input int m, input int s);
    @(negedge clk);
    hour = h[4:0]; min = m[5:0]; sec = s[5:0]; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic convert(input int h, input int m, input int s, input logic [23:0] nibs, input logic rerr);
    q.push_back('{nibs: nibs, rerr: rerr, phased: 1'b0});
    pulse(h, m, s);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || mon_active || busy) && n < 300);
    if (n >= 300) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    q.push_back('{nibs: 24'h000000, rerr: 1'b0, phased: 1'b1});
    #2 rst = 1'b0;
    wait_idle();

    convert(23, 59, 58, 24'h235958, 1'b0);
    repeat (2) @(negedge clk);
    hour = 5'd1; min = 6'd2; sec = 6'd3; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle();

    convert(0, 0, 63, 24'h000063, 1'b1);
    wait_idle();
    convert(0, 0, 0, 24'h000000, 1'b0);
    wait_idle();
    convert(31, 45, 7, 24'h314507, 1'b1);
    wait_idle();
    convert(9, 60, 0, 24'h096000, 1'b1);
    wait_idle();
    convert(12, 59, 59, 24'h125959, 1'b0);
    wait_idle();

    pulse(1, 2, 3);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    q.push_back('{nibs: 24'h000000, rerr: 1'b0, phased: 1'b1});
    #1 chk("busy_async_clear", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_idle();

    convert(12, 34, 56, 24'h123456, 1'b0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
